// File: rtl/video_stream_tx_if.sv
// Raster stream bundle: frame valid, pixel valid and pixel data.
interface video_stream_tx_if #(
  parameter int DW = 8
);
  logic          vvalid;
  logic          hvalid;
  logic [DW-1:0] dout;

  modport master (output vvalid, output hvalid, output dout);
  modport slave  (input  vvalid, input  hvalid, input  dout);
endinterface

// File: rtl/video_stream_tx.sv
// Raster test-pattern transmitter feeding line3_buffer; optional macro
// VST_PATTERN_LFSR_EN turns pattern 3 into LFSR noise (otherwise mid-grey).
module video_stream_tx #(
  parameter int DW = 8,
  parameter int HW = 12,
  parameter int VW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [HW-1:0] h_active,
  input  logic [HW-1:0] h_blank,
  input  logic [VW-1:0] v_active,
  input  logic [VW-1:0] v_blank,
  input  logic [1:0]    pat_sel,
  video_stream_tx_if.master vs,
  output logic          busy,
  output logic          frame_done,
  output logic          cfg_err
);

  // state   | meaning
  // IDLE    | waiting for enable; config latched on start
  // VBLANK  | max(v_blank,1) blank lines of h_active+h_blank cycles
  // ACTIVE  | h_active valid pixels of the current line
  // HBLANK  | h_blank blank cycles closing the line
  typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_ACTIVE, S_HBLANK} state_t;

  localparam logic [HW:0]   X_ONE = 1;
  localparam logic [VW-1:0] Y_ONE = 1;

  state_t        state_q, state_d;
  logic [HW:0]   x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic [HW-1:0] ha_q, ha_d, hb_q, hb_d;
  logic [VW-1:0] va_q, va_d, vb_q, vb_d;
  logic [1:0]    pat_q, pat_d;
  logic          vvalid_q, vvalid_d, hvalid_q, hvalid_d;
  logic [DW-1:0] dout_q, dout_d, pix;
  logic          busy_q, busy_d, frame_done_q, frame_done_d, cfg_err_q, cfg_err_d;
  logic          start, line_end;
  logic [HW:0]   line_last, ha_last, hb_last;
  logic [VW-1:0] va_last, vb_last;
`ifdef VST_PATTERN_LFSR_EN
  logic [15:0]   lfsr_q, lfsr_d;
`endif

  // Widened line length keeps the VBLANK compare safe at all-ones config.
  assign line_last = {1'b0, ha_q} + {1'b0, hb_q} - X_ONE;
  assign ha_last   = {1'b0, ha_q} - X_ONE;
  assign hb_last   = {1'b0, hb_q} - X_ONE;
  assign va_last   = va_q - Y_ONE;
  assign vb_last   = (vb_q == '0) ? '0 : vb_q - Y_ONE;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    ha_d         = ha_q;
    hb_d         = hb_q;
    va_d         = va_q;
    vb_d         = vb_q;
    pat_d        = pat_q;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    start        = 1'b0;
    line_end     = 1'b0;
`ifdef VST_PATTERN_LFSR_EN
    lfsr_d       = lfsr_q;
`endif

    case (state_q)
      S_IDLE: start = enable;
      S_VBLANK: begin
        if (x_q == line_last) begin
          x_d = '0;
          if (y_q == vb_last) begin
            y_d     = '0;
            state_d = S_ACTIVE;
          end else begin
            y_d = y_q + Y_ONE;
          end
        end else begin
          x_d = x_q + X_ONE;
        end
      end
      S_ACTIVE: begin
        if (x_q == ha_last) begin
          x_d = '0;
          if (hb_q == '0) line_end = 1'b1;
          else            state_d  = S_HBLANK;
        end else begin
          x_d = x_q + X_ONE;
        end
      end
      S_HBLANK: begin
        if (x_q == hb_last) begin
          x_d      = '0;
          line_end = 1'b1;
        end else begin
          x_d = x_q + X_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (line_end) begin
      if (y_q == va_last) begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
        start        = enable;
      end else begin
        y_d     = y_q + Y_ONE;
        state_d = S_ACTIVE;
      end
    end

    if (start) begin
      ha_d  = h_active;
      hb_d  = h_blank;
      va_d  = v_active;
      vb_d  = v_blank;
      pat_d = pat_sel;
      x_d   = '0;
      y_d   = '0;
`ifdef VST_PATTERN_LFSR_EN
      lfsr_d = 16'hACE1;
`endif
      if (h_active == '0 || v_active == '0) begin
        cfg_err_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        state_d = S_VBLANK;
      end
    end

    hvalid_d = (state_d == S_ACTIVE);
    vvalid_d = (state_d == S_ACTIVE) || (state_d == S_HBLANK);
    busy_d   = (state_d != S_IDLE);

    case (pat_q)
      2'd0:    pix = DW'(x_d);
      2'd1:    pix = DW'(y_d);
      2'd2:    pix = (x_d[3] ^ y_d[3]) ? '1 : '0;
`ifdef VST_PATTERN_LFSR_EN
      default: pix = DW'(lfsr_q);
`else
      default: pix = DW'(1) << (DW - 1);
`endif
    endcase
    dout_d = hvalid_d ? pix : '0;

`ifdef VST_PATTERN_LFSR_EN
    // Fibonacci taps 16,14,13,11; one step per emitted pixel.
    if (hvalid_d) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      ha_q         <= '0;
      hb_q         <= '0;
      va_q         <= '0;
      vb_q         <= '0;
      pat_q        <= '0;
      vvalid_q     <= 1'b0;
      hvalid_q     <= 1'b0;
      dout_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
`ifdef VST_PATTERN_LFSR_EN
      lfsr_q       <= 16'hACE1;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ha_q         <= ha_d;
      hb_q         <= hb_d;
      va_q         <= va_d;
      vb_q         <= vb_d;
      pat_q        <= pat_d;
      vvalid_q     <= vvalid_d;
      hvalid_q     <= hvalid_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
`ifdef VST_PATTERN_LFSR_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  assign vs.vvalid  = vvalid_q;
  assign vs.hvalid  = hvalid_q;
  assign vs.dout    = dout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_video_stream_tx.sv
// Directed bench for video_stream_tx: compares {busy,vvalid,hvalid,frame_done,cfg_err,dout}
// cycle by cycle against a frame-timing model.
module tb_video_stream_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] h_active = '0, h_blank = '0;
  logic [10:0] v_active = '0, v_blank = '0;
  logic [1:0]  pat_sel = '0;
  logic        busy, frame_done, cfg_err;
  int          n_checks = 0;
  int          n_errors = 0;

  video_stream_tx_if #(.DW(8)) vs_if ();

  video_stream_tx #(.DW(8), .HW(12), .VW(11)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .h_active(h_active), .h_blank(h_blank), .v_active(v_active), .v_blank(v_blank),
    .pat_sel(pat_sel), .vs(vs_if), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] obs_vec();
    return {busy, vs_if.vvalid, vs_if.hvalid, frame_done, cfg_err, vs_if.dout};
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h (busy,vv,hv,fd,err,dout)", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int ha, input int hb, input int va, input int vb, input int pat);
    h_active = 12'(ha);
    h_blank  = 12'(hb);
    v_active = 11'(va);
    v_blank  = 11'(vb);
    pat_sel  = 2'(pat);
  endtask

  // Checks one frame starting at its first VBLANK cycle; vbe is the effective blank-line count.
  task automatic expect_frame(input string tag, input int ha, input int hb, input int va,
                              input int vbe, input int pat, input bit done0, input int drop_at);
    int L, nblank, total, k, line, px;
    logic [15:0] lf;
    logic [7:0]  d;
    logic        hv, vv;
    L      = ha + hb;
    nblank = vbe * L;
    total  = nblank + va * L;
    lf     = 16'hACE1;
    for (int c = 0; c < total; c++) begin
      if (c == drop_at) enable = 1'b0;
      vv = 1'b0; hv = 1'b0; d = 8'h00;
      if (c >= nblank) begin
        k    = c - nblank;
        line = k / L;
        px   = k % L;
        vv   = 1'b1;
        hv   = (px < ha);
        if (hv) begin
          case (pat)
            0: d = 8'(px);
            1: d = 8'(line);
            2: d = (((px >> 3) ^ (line >> 3)) & 1) != 0 ? 8'hFF : 8'h00;
            default: begin
`ifdef VST_PATTERN_LFSR_EN
              d  = lf[7:0];
              lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
`else
              d  = 8'h80;
`endif
            end
          endcase
        end
      end
      check(tag, obs_vec(), {1'b1, vv, hv, (c == 0) && done0, 1'b0, d});
      step();
    end
  endtask

  task automatic expect_end_idle(input string tag);
    check(tag, obs_vec(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    step();
    check({tag, "_idle"}, obs_vec(), 13'h0);
  endtask

  initial begin
    logic fd_seen, busy_seen;

    // reset
    repeat (3) step();
    check("reset", obs_vec(), 13'h0);
    rst = 1'b0;
    step();
    check("idle_no_enable", obs_vec(), 13'h0);

    // 1: single frame, pat0, config scrambled mid-frame must be ignored
    set_cfg(8, 4, 3, 2, 0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    set_cfg(3, 1, 7, 5, 2);
    expect_frame("t1_frame", 8, 4, 3, 2, 0, 1'b0, -1);
    expect_end_idle("t1_end");

    // 2: enable held -> back-to-back frames, drop enable mid second frame
    set_cfg(8, 4, 3, 2, 0);
    enable = 1'b1;
    step();
    expect_frame("t2_frame0", 8, 4, 3, 2, 0, 1'b0, -1);
    expect_frame("t2_frame1", 8, 4, 3, 2, 0, 1'b1, 30);
    expect_end_idle("t2_end");

    // 3: zero h_active rejected
    set_cfg(0, 4, 3, 2, 0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    check("t3_cfg_err", obs_vec(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
    step();
    check("t3_after", obs_vec(), 13'h0);
    set_cfg(4, 4, 0, 2, 0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    check("t3_vact0_err", obs_vec(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
    step();
    check("t3_vact0_after", obs_vec(), 13'h0);

    // 4: no horizontal blank, v_blank clamped to one line, pat1
    set_cfg(4, 0, 2, 0, 1);
    enable = 1'b1;
    step();
    expect_frame("t4_frame0", 4, 0, 2, 1, 1, 1'b0, -1);
    expect_frame("t4_frame1", 4, 0, 2, 1, 1, 1'b1, 2);
    expect_end_idle("t4_end");

    // 5: reset on the third active pixel
    set_cfg(8, 4, 3, 2, 0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (26) step();
    check("t5_pre_rst", obs_vec(), {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst", obs_vec(), 13'h0);
    fd_seen = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      fd_seen   |= frame_done;
      busy_seen |= busy;
    end
    check("t5_no_done", {11'h0, fd_seen, busy_seen}, 13'h0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    expect_frame("t5_restart", 8, 4, 3, 2, 0, 1'b0, -1);
    expect_end_idle("t5_end");

    // 8x8 checker
    set_cfg(16, 2, 10, 1, 2);
    enable = 1'b1;
    step();
    enable = 1'b0;
    expect_frame("chk_frame", 16, 2, 10, 1, 2, 1'b0, -1);
    expect_end_idle("chk_end");

    // 6: pattern 3, two frames must repeat identically
    set_cfg(4, 2, 2, 1, 3);
    enable = 1'b1;
    step();
    expect_frame("t6_frame0", 4, 2, 2, 1, 3, 1'b0, -1);
    expect_frame("t6_frame1", 4, 2, 2, 1, 3, 1'b1, 3);
    expect_end_idle("t6_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
